// File: rtl/fetch_unit.sv
// fetch_unit
//   Sequential instruction fetch front end. Generates word-aligned PCs, keeps up to
//   MAX_OUTSTANDING requests in flight to a latency-tolerant instruction memory and
//   buffers returned words, tagged with their PCs, in a DEPTH-entry in-order queue
//   that feeds decode. A redirect restarts fetch at a new PC, empties the queue and
//   marks every in-flight response to be discarded when it returns.
//
// Ports
//   clock, reset        single clock; synchronous active-high reset
//   redirect_valid/_pc  restart fetch at redirect_pc (low two bits ignored)
//   imem_req_*          request channel (valid/ready, word address)
//   imem_resp_*         in-order response channel (no backpressure)
//   inst_*              queue head toward decode (valid/ready, word and its PC)
//   outstanding         requests accepted but not yet answered

module fetch_unit #(
    parameter int                XLEN            = 32,
    parameter int                DEPTH           = 4,
    parameter int                MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0]   RESET_PC        = XLEN'(32'h0100_0000),
    localparam int               OW_RAW          = $clog2(MAX_OUTSTANDING + 1),
    localparam int               OW              = (OW_RAW < 3) ? 3 : OW_RAW
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc,
    output logic [OW-1:0]   outstanding
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic [XLEN-1:0] r_q_data [DEPTH];
    logic [XLEN-1:0] r_q_pc   [DEPTH];
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic [OW-1:0]   r_outstanding;
    logic [OW-1:0]   r_drop_cnt;

    logic [31:0]     w_used;
    logic            w_credit_ok;
    logic            w_slot_ok;
    logic            w_req_fire;
    logic            w_push;
    logic            w_pop;
    logic [XLEN-1:0] w_redirect_pc;

    // Queue slots already spoken for: words held plus live (non-squashed) requests.
    // Requesting only while this is below DEPTH guarantees every push finds room.
    assign w_used      = 32'(r_count) + 32'(r_outstanding) - 32'(r_drop_cnt);
    assign w_credit_ok = (w_used < 32'(DEPTH));
    assign w_slot_ok   = (r_outstanding < OW'(MAX_OUTSTANDING));

    assign imem_req_valid = !reset && !redirect_valid && w_credit_ok && w_slot_ok;
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    // Head is hidden in a redirect cycle so decode never consumes a squashed word.
    assign inst_valid = !reset && !redirect_valid && (r_count != '0);
    assign inst_data  = reset ? '0 : r_q_data[r_rd_ptr];
    assign inst_pc    = reset ? '0 : r_q_pc[r_rd_ptr];
    assign w_pop      = inst_valid && inst_ready;

    assign w_push        = imem_resp_valid && (r_drop_cnt == '0);
    assign w_redirect_pc = redirect_pc & ~XLEN'(3);

    assign outstanding = r_outstanding;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q_data[i] <= '0;
                r_q_pc[i]   <= '0;
            end
        end else if (redirect_valid) begin
            // No request goes out this cycle; a same-cycle response is discarded
            // and everything still in flight afterwards must be dropped on return.
            r_fetch_pc    <= w_redirect_pc;
            r_resp_pc     <= w_redirect_pc;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= r_outstanding - OW'(imem_resp_valid);
            r_drop_cnt    <= r_outstanding - OW'(imem_resp_valid);
        end else begin
            r_outstanding <= r_outstanding + OW'(w_req_fire) - OW'(imem_resp_valid);
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + XLEN'(4);
            end
            if (imem_resp_valid) begin
                if (r_drop_cnt != '0) begin
                    r_drop_cnt <= r_drop_cnt - OW'(1);
                end else begin
                    r_q_data[r_wr_ptr] <= imem_resp_data;
                    r_q_pc[r_wr_ptr]   <= r_resp_pc;
                    r_wr_ptr           <= r_wr_ptr + AW'(1);
                    r_resp_pc          <= r_resp_pc + XLEN'(4);
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int          DEPTH    = 4;
    localparam int          MAXO     = 2;
    localparam logic [31:0] RESET_PC = 32'h0100_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [2:0]  outstanding;

    always #5 clock = ~clock;

    fetch_unit #(
        .XLEN(32), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RESET_PC)
    ) dut (
        .clock(clock), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_data(inst_data), .inst_pc(inst_pc),
        .outstanding(outstanding)
    );

    // Memory model: accepted requests answered in order, one per cycle, after a latency.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t pend[$];

    typedef struct {
        logic [31:0] rpc;
        logic [31:0] exp_addr;
    } vec_t;

    int          cyc, last_due, tb_out, consumed;
    logic [31:0] exp_req, exp_pc;
    int          n_checks, n_errors;

    logic        t_rst, t_redir, t_req_ready, t_inst_ready;
    logic [31:0] t_redir_pc;
    int          lat;

    logic        s_req_valid, s_inst_valid, s_fire, s_pop, s_resp;
    logic [31:0] s_addr, s_pc, s_data;
    logic [2:0]  s_out;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_1E0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive, sample mid-cycle, check against the model, advance.
    task automatic step();
        reset          = t_rst;
        redirect_valid = t_redir;
        redirect_pc    = t_redir_pc;
        imem_req_ready = t_req_ready;
        inst_ready     = t_inst_ready;
        if (!t_rst && pend.size() > 0 && pend[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = word_of(pend[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
        #3;
        s_req_valid  = imem_req_valid;
        s_addr       = imem_req_addr;
        s_inst_valid = inst_valid;
        s_pc         = inst_pc;
        s_data       = inst_data;
        s_out        = outstanding;
        s_resp       = imem_resp_valid;
        s_fire       = s_req_valid && t_req_ready;
        s_pop        = s_inst_valid && t_inst_ready;

        chk("outstanding", 32'(s_out), 32'(tb_out));
        if (t_rst) begin
            chk("rst_req_valid", 32'(s_req_valid), 32'd0);
            chk("rst_inst_valid", 32'(s_inst_valid), 32'd0);
            chk("rst_inst_data", s_data, 32'd0);
            chk("rst_inst_pc", s_pc, 32'd0);
            pend.delete();
            tb_out   = 0;
            last_due = 0;
            exp_req  = RESET_PC;
            exp_pc   = RESET_PC;
        end else begin
            if (t_redir) begin
                chk("redir_req_valid", 32'(s_req_valid), 32'd0);
                chk("redir_inst_valid", 32'(s_inst_valid), 32'd0);
            end else begin
                if (s_fire) chk("req_addr", s_addr, exp_req);
                if (s_pop) begin
                    chk("inst_pc", s_pc, exp_pc);
                    chk("inst_data", s_data, word_of(exp_pc));
                end
            end
            if (s_resp) begin
                void'(pend.pop_front());
                tb_out--;
            end
            if (s_fire && !t_redir) begin
                mreq_t m;
                m.addr = s_addr;
                m.due  = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                last_due = m.due;
                pend.push_back(m);
                tb_out++;
                exp_req += 32'd4;
            end
            if (s_pop && !t_redir) begin
                exp_pc += 32'd4;
                consumed++;
            end
            if (t_redir) begin
                exp_req = t_redir_pc & 32'hFFFF_FFFC;
                exp_pc  = t_redir_pc & 32'hFFFF_FFFC;
            end
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int n);
        t_rst   = 1'b1;
        t_redir = 1'b0;
        repeat (n) step();
        t_rst = 1'b0;
    endtask

    vec_t vec[4];

    initial begin
        int          nacc, c0, cstart;
        logic [31:0] first_addr, first_pc, first_data;
        logic        got_addr, got_pc;

        n_checks = 0; n_errors = 0; cyc = 0; consumed = 0;
        tb_out = 0; last_due = 0; exp_req = RESET_PC; exp_pc = RESET_PC;
        t_rst = 1'b1; t_redir = 1'b0; t_redir_pc = 32'h0;
        t_req_ready = 1'b1; t_inst_ready = 1'b1; lat = 1;
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
        inst_ready = 1'b0;
        @(posedge clock);
        #1;

        // Streaming from reset with a 1-cycle memory: one word per cycle.
        do_reset(3);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t1_req_valid", 32'(s_req_valid), 32'd1);
            chk("t1_req_addr", s_addr, RESET_PC + 32'(4 * k));
            chk("t1_inst_valid", 32'(s_inst_valid), 32'(k >= 2));
            if (k >= 2) chk("t1_inst_pc", s_pc, RESET_PC + 32'(4 * (k - 2)));
        end

        // Decode stalled: exactly DEPTH words fetched, then requests stop.
        t_inst_ready = 1'b0;
        do_reset(2);
        nacc = 0;
        repeat (12) begin
            step();
            if (s_fire) nacc++;
        end
        chk("t2_fill_reqs", 32'(nacc), 32'(DEPTH));
        chk("t2_req_stalled", 32'(s_req_valid), 32'd0);
        chk("t2_head_held", 32'(s_inst_valid), 32'd1);
        t_inst_ready = 1'b1;
        c0 = consumed;
        repeat (16) step();
        chk("t2_resume", 32'(consumed - c0 >= 12), 32'd1);

        // Redirect with two requests in flight on a 3-cycle memory.
        lat = 3;
        do_reset(2);
        step();
        step();
        t_redir = 1'b1; t_redir_pc = 32'h0100_0203;
        step();
        chk("t3_out_at_redirect", 32'(s_out), 32'd2);
        t_redir = 1'b0;
        got_addr = 1'b0; got_pc = 1'b0;
        first_addr = 32'hDEAD_BEEF; first_pc = 32'hDEAD_BEEF; first_data = 32'hDEAD_BEEF;
        repeat (20) begin
            step();
            if (s_fire && !got_addr) begin got_addr = 1'b1; first_addr = s_addr; end
            if (s_inst_valid && !got_pc) begin
                got_pc = 1'b1; first_pc = s_pc; first_data = s_data;
            end
        end
        chk("t3_first_addr", first_addr, 32'h0100_0200);
        chk("t3_first_pc", first_pc, 32'h0100_0200);
        chk("t3_first_data", first_data, word_of(32'h0100_0200));

        // Redirect coinciding with a response and a pop.
        lat = 1;
        do_reset(2);
        step();
        step();
        step();
        chk("t4_head_valid", 32'(s_inst_valid), 32'd1);
        t_redir = 1'b1; t_redir_pc = 32'h0200_0000;
        step();
        chk("t4_redir_inst_valid", 32'(s_inst_valid), 32'd0);
        t_redir = 1'b0;
        step();
        chk("t4_empty_after", 32'(s_inst_valid), 32'd0);
        chk("t4_next_req_valid", 32'(s_req_valid), 32'd1);
        chk("t4_next_req_addr", s_addr, 32'h0200_0000);
        repeat (6) step();

        // Redirect alignment table, memory held off so no request is accepted.
        vec[0] = '{32'h0100_0203, 32'h0100_0200};
        vec[1] = '{32'h0000_0001, 32'h0000_0000};
        vec[2] = '{32'h1234_5678, 32'h1234_5678};
        vec[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC};
        t_req_ready = 1'b0;
        do_reset(2);
        for (int i = 0; i < 4; i++) begin
            t_redir = 1'b1; t_redir_pc = vec[i].rpc;
            step();
            t_redir = 1'b0;
            step();
            chk("tab_req_valid", 32'(s_req_valid), 32'd1);
            chk("tab_req_addr", s_addr, vec[i].exp_addr);
        end
        // Address wrap past the top of the address space.
        t_req_ready = 1'b1;
        step();
        chk("t5_fire0", 32'(s_fire), 32'd1);
        chk("t5_addr0", s_addr, 32'hFFFF_FFFC);
        step();
        chk("t5_fire1", 32'(s_fire), 32'd1);
        chk("t5_addr1", s_addr, 32'h0000_0000);
        repeat (6) step();

        // Reset with work in flight and words queued.
        lat = 3; t_inst_ready = 1'b0;
        do_reset(2);
        repeat (6) step();
        t_rst = 1'b1;
        step();
        chk("t6_out_at_reset", 32'(s_out), 32'd2);
        t_rst = 1'b0;
        step();
        chk("t6_out_cleared", 32'(s_out), 32'd0);
        chk("t6_no_stale_valid", 32'(s_inst_valid), 32'd0);
        chk("t6_req_valid", 32'(s_req_valid), 32'd1);
        chk("t6_req_addr", s_addr, RESET_PC);
        t_inst_ready = 1'b1;
        repeat (8) step();

        // Randomised traffic against the stream model.
        do_reset(2);
        cstart = consumed;
        for (int n = 0; n < 3000; n++) begin
            t_req_ready  = ($urandom % 4) != 0;
            t_inst_ready = ($urandom % 3) != 0;
            lat          = $urandom_range(1, 4);
            t_redir      = ($urandom % 20) == 0;
            t_redir_pc   = ($urandom % 2 == 0) ? $urandom
                                                : 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            t_rst        = ($urandom % 400) == 0;
            step();
        end
        t_rst = 1'b0; t_redir = 1'b0; t_req_ready = 1'b1; t_inst_ready = 1'b1;
        repeat (30) step();
        chk("rand_progress", 32'(consumed - cstart >= 300), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
